tlb_maint: RTL and testbench
============================

TLB_MAINT -- requirements
Module: tlb_maint

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, number of TLB entries; IW = clog2(TLBNUM).
REQ-002 SHALL carry an entry bundle ENT[88:0] = {e, vppn[18:0], ps[5:0], asid[9:0], g, ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0, ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1}, MSB first.
REQ-003 SHALL have one clock and an asynchronous active-low reset, with ports listed below.
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  operation request.
- req_ready  out  1  block can accept a request.
- req_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV.
- req_invop  in  5  INVTLB sub-op (INV only).
- req_asid  in  10  ASID for SRCH/INV.
- req_vppn  in  19  VPPN for SRCH/INV.
- req_index  in  IW  entry index for RD/WR.
- req_entry  in  89  ENT to write (WR/FILL).
- resp_valid  out  1  one-cycle completion pulse.
- resp_found  out  1  SRCH hit / RD entry valid.
- resp_index  out  IW  SRCH hit index / FILL chosen index.
- resp_entry  out  89  RD data.
- resp_err  out  1  illegal op or sub-op.
- tlb_s_vppn  out  19  search port VPPN.
- tlb_s_asid  out  10  search port ASID.
- tlb_s_found  in  1  search hit.
- tlb_s_index  in  IW  search hit index.
- tlb_r_index  out  IW  read-port index.
- tlb_r_entry  in  89  combinational read data.
- tlb_we  out  1  write enable.
- tlb_w_index  out  IW  write index.
- tlb_w_entry  out  89  write data.

Function
REQ-004 SHALL use states IDLE, EXEC, SCAN, RESP; req_ready SHALL be 1 only in IDLE.
REQ-005 SHALL accept a request in IDLE when req_valid=1 and latch all req_* fields; requests in other states are ignored.
REQ-006 SHALL go IDLE->EXEC for ops 0-3, IDLE->SCAN for op 4, and IDLE->RESP with resp_err=1 for op>4.
REQ-007 SHALL leave EXEC for RESP after exactly one cycle, and leave RESP for IDLE after one cycle; resp_valid=1 only in RESP (no backpressure).
REQ-008 SRCH SHALL drive tlb_s_vppn/asid from latched values in EXEC and register tlb_s_found/tlb_s_index into resp_found/resp_index.
REQ-009 RD SHALL drive tlb_r_index=latched index in EXEC, register tlb_r_entry into resp_entry, and set resp_found=tlb_r_entry.e.
REQ-010 WR SHALL assert tlb_we for the single EXEC cycle with w_index=latched index and w_entry=latched entry.
REQ-011 FILL SHALL behave as WR but use w_index = value of a free-running IW-bit counter (increments every cycle, wraps TLBNUM-1->0) sampled at accept; resp_index SHALL report it.
REQ-012 INV SHALL scan i=0..TLBNUM-1, one entry per cycle: tlb_r_index=i, and if entry matches, tlb_we=1, w_index=i, w_entry=tlb_r_entry with e=0.
REQ-013 INV match SHALL require e=1 and: op0/1 any; op2 g=1; op3 g=0; op4 g=0 and asid eq; op5 g=0, asid eq, va eq; op6 (g=1 or asid eq) and va eq; op7-31 illegal (no scan, resp_err=1, no writes).
REQ-014 va eq SHALL mean vppn[18:10] equal and (ps==22 or vppn[9:0] equal).
REQ-015 SCAN SHALL last exactly TLBNUM cycles, then go to RESP; tlb_we SHALL never be asserted outside EXEC (WR/FILL) or SCAN.
REQ-016 Latency SHALL be accept at T, resp_valid at T+2 (ops 0-3), T+TLBNUM+1 (INV), T+1 (error).
REQ-017 resp_* SHALL hold their values until the next response and SHALL reset to 0 between operations only via reset.

Reset
REQ-018 On resetn=0 SHALL immediately enter IDLE with req_ready=1 and tlb_we, resp_valid, resp_found, resp_err, resp_index, resp_entry and the FILL counter all 0.
REQ-019 A reset mid-SCAN SHALL abort the scan, with no further writes after reset is asserted.

Verification
REQ-020 WR idx 5, entry e=1 vppn=0x1234 -> tlb_we one cycle at T+1 with w_index=5; then RD 5 -> resp_found=1, resp_entry equals the written entry, at T+2.
REQ-021 SRCH vppn=0x1234 asid matching -> resp_found=1, resp_index=5; with unmatched non-global asid -> resp_found=0.
REQ-022 INV op2 with entries 3 (g=1) and 4 (g=0) valid -> exactly one write (index 3, e=0), resp_valid at T+17, entry 4 intact.
REQ-023 INV op5 on a 4MB entry (ps=22) with vppn differing only in [9:0] -> entry invalidated; same case with ps=12 -> not invalidated.
REQ-024 INV op9 -> resp_err=1 at T+1 and no tlb_we; req_valid during SCAN -> not accepted, req_ready=0.
REQ-025 FILL accepted 7 cycles after reset release -> w_index=7, resp_index=7; resetn pulsed during SCAN -> tlb_we=0 at once, IDLE with req_ready=1.

Source files
------------

// File: rtl/tlb_maint.sv
// rtl/tlb_maint.sv - TLB maintenance sequencer: search, read, write, fill and INVTLB scan
module tlb_maint #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_invop,
    input  logic [9:0]    req_asid,
    input  logic [18:0]   req_vppn,
    input  logic [IW-1:0] req_index,
    input  logic [88:0]   req_entry,
    output logic          resp_valid,
    output logic          resp_found,
    output logic [IW-1:0] resp_index,
    output logic [88:0]   resp_entry,
    output logic          resp_err,
    output logic [18:0]   tlb_s_vppn,
    output logic [9:0]    tlb_s_asid,
    input  logic          tlb_s_found,
    input  logic [IW-1:0] tlb_s_index,
    output logic [IW-1:0] tlb_r_index,
    input  logic [88:0]   tlb_r_entry,
    output logic          tlb_we,
    output logic [IW-1:0] tlb_w_index,
    output logic [88:0]   tlb_w_entry
);

    localparam logic [2:0]    OP_SRCH  = 3'd0;
    localparam logic [2:0]    OP_RD    = 3'd1;
    localparam logic [2:0]    OP_WR    = 3'd2;
    localparam logic [2:0]    OP_FILL  = 3'd3;
    localparam logic [2:0]    OP_INV   = 3'd4;
    localparam logic [4:0]    INV_MAX  = 5'd6;
    localparam logic [IW-1:0] LAST_IDX = IW'(TLBNUM - 1);

    typedef enum logic [1:0] {IDLE, EXEC, SCAN, RESP} state_t;

    state_t        state_q;
    logic [2:0]    op_q;
    logic [4:0]    invop_q;
    logic [9:0]    asid_q;
    logic [18:0]   vppn_q;
    logic [IW-1:0] index_q;
    logic [88:0]   entry_q;
    logic [IW-1:0] cnt_q;
    logic [IW-1:0] cnt_d;
    logic [IW-1:0] fill_q;
    logic [IW-1:0] scan_q;
    logic          resp_valid_q;
    logic          resp_found_q;
    logic [IW-1:0] resp_index_q;
    logic [88:0]   resp_entry_q;
    logic          resp_err_q;

    logic          r_e;
    logic          r_g;
    logic [18:0]   r_vppn;
    logic [5:0]    r_ps;
    logic [9:0]    r_asid;
    logic          asid_eq;
    logic          va_eq;
    logic          inv_sel;
    logic          inv_hit;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_found = resp_found_q;
    assign resp_index = resp_index_q;
    assign resp_entry = resp_entry_q;
    assign resp_err   = resp_err_q;
    assign tlb_s_vppn = vppn_q;
    assign tlb_s_asid = asid_q;

    assign cnt_d  = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;

    assign r_e    = tlb_r_entry[88];
    assign r_vppn = tlb_r_entry[87:69];
    assign r_ps   = tlb_r_entry[68:63];
    assign r_asid = tlb_r_entry[62:53];
    assign r_g    = tlb_r_entry[52];

    // INVTLB match of the entry currently on the read port against the latched request
    always_comb begin
        asid_eq = (r_asid == asid_q);
        va_eq   = (r_vppn[18:10] == vppn_q[18:10]) &&
                  ((r_ps == 6'd22) || (r_vppn[9:0] == vppn_q[9:0]));
        inv_sel = 1'b0;
        case (invop_q)
            5'd0, 5'd1: inv_sel = 1'b1;
            5'd2:       inv_sel = r_g;
            5'd3:       inv_sel = !r_g;
            5'd4:       inv_sel = !r_g && asid_eq;
            5'd5:       inv_sel = !r_g && asid_eq && va_eq;
            5'd6:       inv_sel = (r_g || asid_eq) && va_eq;
            default:    inv_sel = 1'b0;
        endcase
        inv_hit = r_e && inv_sel;
    end

    // TLB read/write port steering; writes only in EXEC (WR/FILL) or on an INV hit in SCAN
    always_comb begin
        tlb_we      = 1'b0;
        tlb_r_index = index_q;
        tlb_w_index = index_q;
        tlb_w_entry = entry_q;
        case (state_q)
            EXEC: begin
                if (op_q == OP_WR) begin
                    tlb_we = 1'b1;
                end else if (op_q == OP_FILL) begin
                    tlb_we      = 1'b1;
                    tlb_w_index = fill_q;
                end
            end
            SCAN: begin
                tlb_r_index = scan_q;
                tlb_w_index = scan_q;
                tlb_w_entry = {1'b0, tlb_r_entry[87:0]};
                tlb_we      = inv_hit;
            end
            default: ;
        endcase
    end

    // Control FSM with request latch, fill counter, scan pointer and registered response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            op_q         <= '0;
            invop_q      <= '0;
            asid_q       <= '0;
            vppn_q       <= '0;
            index_q      <= '0;
            entry_q      <= '0;
            cnt_q        <= '0;
            fill_q       <= '0;
            scan_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_found_q <= 1'b0;
            resp_index_q <= '0;
            resp_entry_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        invop_q <= req_invop;
                        asid_q  <= req_asid;
                        vppn_q  <= req_vppn;
                        index_q <= req_index;
                        entry_q <= req_entry;
                        fill_q  <= cnt_q;
                        scan_q  <= '0;
                        if (req_op < OP_INV) begin
                            state_q <= EXEC;
                        end else if ((req_op == OP_INV) && (req_invop <= INV_MAX)) begin
                            state_q <= SCAN;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    case (op_q)
                        OP_SRCH: begin
                            resp_found_q <= tlb_s_found;
                            resp_index_q <= tlb_s_index;
                        end
                        OP_RD: begin
                            resp_found_q <= tlb_r_entry[88];
                            resp_entry_q <= tlb_r_entry;
                        end
                        OP_FILL: resp_index_q <= fill_q;
                        default: ;
                    endcase
                end
                SCAN: begin
                    scan_q <= scan_q + 1'b1;
                    if (scan_q == LAST_IDX) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_maint.sv
// tb/tb_tlb_maint.sv - scoreboard bench for tlb_maint with a TLB storage model and reference model
module tb_tlb_maint;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_invop;
    logic [9:0]  req_asid;
    logic [18:0] req_vppn;
    logic [3:0]  req_index;
    logic [88:0] req_entry;
    logic        resp_valid;
    logic        resp_found;
    logic [3:0]  resp_index;
    logic [88:0] resp_entry;
    logic        resp_err;
    logic [18:0] tlb_s_vppn;
    logic [9:0]  tlb_s_asid;
    logic        tlb_s_found;
    logic [3:0]  tlb_s_index;
    logic [3:0]  tlb_r_index;
    logic [88:0] tlb_r_entry;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic [88:0] tlb_w_entry;

    always #5 clk = ~clk;

    tlb_maint #(.TLBNUM(N)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_invop(req_invop),
        .req_asid(req_asid), .req_vppn(req_vppn), .req_index(req_index), .req_entry(req_entry),
        .resp_valid(resp_valid), .resp_found(resp_found), .resp_index(resp_index),
        .resp_entry(resp_entry), .resp_err(resp_err),
        .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid), .tlb_s_found(tlb_s_found),
        .tlb_s_index(tlb_s_index), .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry)
    );

    typedef struct {
        int          cyc;
        int          err;
        bit          cf;
        int          found;
        bit          ci;
        int          idx;
        bit          ce;
        logic [88:0] ent;
    } resp_t;

    typedef struct {
        int          cyc;
        int          idx;
        logic [88:0] ent;
    } wr_t;

    resp_t       rq[$];
    wr_t         wq[$];
    resp_t       mon_r;
    wr_t         mon_w;
    logic [88:0] tb_mem    [N];
    logic [88:0] model_mem [N];
    int          cyc = 0;
    int          rel_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_ent(input string name, input logic [88:0] act, input logic [88:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [88:0] mk(input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                                       input logic [9:0] asid, input logic g, input logic [51:0] rest);
        return {e, vppn, ps, asid, g, rest};
    endfunction

    // Search rule of the TLB itself: valid, global-or-same-ASID, VPPN equal down to the page size
    function automatic bit s_hit(input logic [88:0] ent, input logic [18:0] va, input logic [9:0] as);
        logic [18:0] ev  = ent[87:69];
        logic [5:0]  eps = ent[68:63];
        if (!ent[88]) return 1'b0;
        if (!ent[52] && (ent[62:53] != as)) return 1'b0;
        if (ev[18:10] != va[18:10]) return 1'b0;
        return (eps == 6'd22) || (ev[9:0] == va[9:0]);
    endfunction

    // INVTLB selection rule per sub-op
    function automatic bit inv_match(input logic [88:0] ent, input int invop,
                                     input logic [9:0] as, input logic [18:0] va);
        bit g   = ent[52];
        bit aeq = (ent[62:53] == as);
        bit veq = (ent[87:79] == va[18:10]) && ((ent[68:63] == 6'd22) || (ent[78:69] == va[9:0]));
        if (!ent[88]) return 1'b0;
        case (invop)
            0, 1:    return 1'b1;
            2:       return g;
            3:       return !g;
            4:       return !g && aeq;
            5:       return !g && aeq && veq;
            6:       return (g || aeq) && veq;
            default: return 1'b0;
        endcase
    endfunction

    // TLB storage: combinational search/read ports, write on the clock edge
    always @(posedge clk) if (tlb_we) tb_mem[tlb_w_index] <= tlb_w_entry;
    assign tlb_r_entry = tb_mem[tlb_r_index];
    always_comb begin
        tlb_s_found = 1'b0;
        tlb_s_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (s_hit(tb_mem[i], tlb_s_vppn, tlb_s_asid)) begin
                tlb_s_found = 1'b1;
                tlb_s_index = 4'(i);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_resp(input int c, input int err, input bit cf, input int f,
                             input bit ci, input int idx, input bit ce, input logic [88:0] ent);
        resp_t r;
        r.cyc = c; r.err = err; r.cf = cf; r.found = f; r.ci = ci; r.idx = idx; r.ce = ce; r.ent = ent;
        rq.push_back(r);
    endtask

    task automatic push_wr(input int c, input int idx, input logic [88:0] ent);
        wr_t w;
        w.cyc = c; w.idx = idx; w.ent = ent;
        wq.push_back(w);
    endtask

    // Issue one request; the reference model updates and queues expectations (t = accept cycle)
    task automatic issue(input int op, input int invop, input logic [9:0] asid, input logic [18:0] vppn,
                         input int idx, input logic [88:0] ent, input bit abort);
        int n = 0;
        int t;
        int f;
        int fi;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", int'(req_ready), 1);
        req_op = 3'(op); req_invop = 5'(invop); req_asid = asid; req_vppn = vppn;
        req_index = 4'(idx); req_entry = ent; req_valid = 1'b1;
        t = cyc;
        if (!abort) begin
            case (op)
                0: begin
                    f = 0; fi = 0;
                    for (int i = N - 1; i >= 0; i--)
                        if (s_hit(model_mem[i], vppn, asid)) begin f = 1; fi = i; end
                    push_resp(t + 2, 0, 1'b1, f, f != 0, fi, 1'b0, '0);
                end
                1: push_resp(t + 2, 0, 1'b1, int'(model_mem[idx][88]), 1'b0, 0, 1'b1, model_mem[idx]);
                2: begin
                    model_mem[idx] = ent;
                    push_wr(t + 1, idx, ent);
                    push_resp(t + 2, 0, 1'b0, 0, 1'b0, 0, 1'b0, '0);
                end
                3: begin
                    fi = (t - rel_cyc) % N;
                    model_mem[fi] = ent;
                    push_wr(t + 1, fi, ent);
                    push_resp(t + 2, 0, 1'b0, 0, 1'b1, fi, 1'b0, '0);
                end
                4: begin
                    if (invop > 6) begin
                        push_resp(t + 1, 1, 1'b0, 0, 1'b0, 0, 1'b0, '0);
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            if (inv_match(model_mem[i], invop, asid, vppn)) begin
                                model_mem[i][88] = 1'b0;
                                push_wr(t + 1 + i, i, model_mem[i]);
                            end
                        end
                        push_resp(t + N + 1, 0, 1'b0, 0, 1'b0, 0, 1'b0, '0);
                    end
                end
                default: push_resp(t + 1, 1, 1'b0, 0, 1'b0, 0, 1'b0, '0);
            endcase
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Response monitor: pop the scoreboard whenever a completion pulse is seen
    always @(negedge clk) begin
        if (resetn === 1'b1 && resp_valid === 1'b1) begin
            if (rq.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_extra: got a response at cycle %0d expected none", cyc);
            end else begin
                mon_r = rq.pop_front();
                chk("resp_cycle", cyc, mon_r.cyc);
                chk("resp_err", int'(resp_err), mon_r.err);
                if (mon_r.cf) chk("resp_found", int'(resp_found), mon_r.found);
                if (mon_r.ci) chk("resp_index", int'(resp_index), mon_r.idx);
                if (mon_r.ce) chk_ent("resp_entry", resp_entry, mon_r.ent);
            end
        end
    end

    // Write monitor: every TLB write must match the next expected write exactly
    always @(negedge clk) begin
        if (resetn === 1'b1 && tlb_we === 1'b1) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL write_extra: got write idx %0d at cycle %0d expected none", tlb_w_index, cyc);
            end else begin
                mon_w = wq.pop_front();
                chk("write_cycle", cyc, mon_w.cyc);
                chk("write_index", int'(tlb_w_index), mon_w.idx);
                chk_ent("write_entry", tlb_w_entry, mon_w.ent);
            end
        end
    end

    function automatic logic [18:0] pick_vppn();
        case ($urandom_range(0, 3))
            0:       return 19'h01234;
            1:       return 19'h01234 ^ 19'h000F0;
            2:       return 19'h02455;
            default: return 19'h027AA;
        endcase
    endfunction

    function automatic logic [88:0] rand_entry();
        return mk($urandom_range(0, 3) != 0, pick_vppn(), ($urandom_range(0, 1) != 0) ? 6'd22 : 6'd12,
                  10'($urandom_range(1, 3)), $urandom_range(0, 3) == 0, {20'($urandom), 32'($urandom)});
    endfunction

    initial begin
        int op;
        int n;
        for (int i = 0; i < N; i++) begin
            tb_mem[i] = '0;
            model_mem[i] = '0;
        end
        req_valid = 1'b0; req_op = '0; req_invop = '0; req_asid = '0; req_vppn = '0;
        req_index = '0; req_entry = '0;
        resetn = 1'b0;
        #1;
        chk("rst_ready", int'(req_ready), 1);
        chk("rst_valid", int'(resp_valid), 0);
        chk("rst_found", int'(resp_found), 0);
        chk("rst_err", int'(resp_err), 0);
        chk("rst_index", int'(resp_index), 0);
        chk_ent("rst_entry", resp_entry, '0);
        chk("rst_we", int'(tlb_we), 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        rel_cyc = cyc;

        // FILL accepted in the 7th cycle after release lands on index 7
        repeat (6) @(negedge clk);
        issue(3, 0, 0, 0, 0, mk(1'b1, 19'h00777, 6'd12, 10'd2, 1'b0, 52'h1), 1'b0);

        // WR 5 then RD 5, then searches with matching and non-matching ASID
        issue(2, 0, 0, 0, 5, mk(1'b1, 19'h01234, 6'd12, 10'd1, 1'b0, 52'hABCDE_12345678), 1'b0);
        issue(1, 0, 0, 0, 5, '0, 1'b0);
        issue(0, 0, 10'd1, 19'h01234, 0, '0, 1'b0);
        issue(0, 0, 10'd2, 19'h01234, 0, '0, 1'b0);

        // INV op2 removes only the global entry
        issue(2, 0, 0, 0, 3, mk(1'b1, 19'h00333, 6'd12, 10'd1, 1'b1, 52'h3), 1'b0);
        issue(2, 0, 0, 0, 4, mk(1'b1, 19'h00444, 6'd12, 10'd1, 1'b0, 52'h4), 1'b0);
        issue(4, 2, 0, 0, 0, '0, 1'b0);
        issue(1, 0, 0, 0, 4, '0, 1'b0);

        // INV op5: 4MB page ignores vppn[9:0], 4KB page does not
        issue(2, 0, 0, 0, 6, mk(1'b1, 19'h02455, 6'd22, 10'd3, 1'b0, 52'h6), 1'b0);
        issue(4, 5, 10'd3, 19'h027AA, 0, '0, 1'b0);
        issue(1, 0, 0, 0, 6, '0, 1'b0);
        issue(2, 0, 0, 0, 6, mk(1'b1, 19'h02455, 6'd12, 10'd3, 1'b0, 52'h6), 1'b0);
        issue(4, 5, 10'd3, 19'h027AA, 0, '0, 1'b0);
        issue(1, 0, 0, 0, 6, '0, 1'b0);

        // Illegal sub-op and illegal op
        issue(4, 9, 0, 0, 0, '0, 1'b0);
        issue(6, 0, 0, 0, 0, '0, 1'b0);

        // Requests presented during a scan are not accepted
        issue(4, 3, 10'd1, 19'h00444, 0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            req_op = 3'd1; req_valid = 1'b1;
            chk("ready_in_scan", int'(req_ready), 0);
        end
        @(negedge clk);
        req_valid = 1'b0;

        // Reset in the middle of an INV-all scan aborts it before any hit is reached
        issue(2, 0, 0, 0, 9, mk(1'b1, 19'h00999, 6'd12, 10'd1, 1'b0, 52'h9), 1'b0);
        issue(4, 1, 0, 0, 0, '0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("abort_we", int'(tlb_we), 0);
        chk("abort_ready", int'(req_ready), 1);
        chk("abort_valid", int'(resp_valid), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_we_hold", int'(tlb_we), 0);
        end
        resetn = 1'b1;
        rel_cyc = cyc;
        issue(1, 0, 0, 0, 9, '0, 1'b0);

        // Randomized mix against the reference model
        for (int k = 0; k < 60; k++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1:    issue(0, 0, 10'($urandom_range(1, 3)), pick_vppn(), 0, '0, 1'b0);
                2, 9:    issue(1, 0, 0, 0, $urandom_range(0, N - 1), '0, 1'b0);
                3, 4:    issue(2, 0, 0, 0, $urandom_range(0, N - 1), rand_entry(), 1'b0);
                5:       issue(3, 0, 0, 0, 0, rand_entry(), 1'b0);
                6, 7:    issue(4, $urandom_range(0, 9), 10'($urandom_range(1, 3)), pick_vppn(), 0, '0, 1'b0);
                default: issue($urandom_range(5, 7), 0, 0, 0, 0, '0, 1'b0);
            endcase
        end

        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("resp_queue_drained", rq.size(), 0);
        chk("write_queue_drained", wq.size(), 0);
        for (int i = 0; i < N; i++) chk_ent("final_mem", tb_mem[i], model_mem[i]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
